// File: rtl/fetch_unit_pkg.sv
// Shared encodings for the instruction-fetch stage: next-PC select codes,
// fetch FSM states and the default reset PC.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      PC_SRC_SEQ    = 2'b00,
      PC_SRC_BRANCH = 2'b01,
      PC_SRC_JUMP   = 2'b10,
      PC_SRC_HOLD   = 2'b11
   } pc_src_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC select: sequential increment, branch, jump or hold.
// Shared with the branch unit, so it carries no state of its own.
module pc_next_mux
   import fetch_unit_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int PC_INC     = 1
) (
   input  logic [ADDR_WIDTH-1:0] pc,
   input  logic [1:0]            pc_src,
   input  logic [ADDR_WIDTH-1:0] branch_target,
   input  logic [ADDR_WIDTH-1:0] jump_target,
   output logic [ADDR_WIDTH-1:0] pc_next
);

   localparam logic [ADDR_WIDTH-1:0] INC = ADDR_WIDTH'(PC_INC);

   // Increment wraps naturally at 2^ADDR_WIDTH.
   always_comb begin
      pc_next = pc;
      case (pc_src_e'(pc_src))
         PC_SRC_SEQ:    pc_next = pc + INC;
         PC_SRC_BRANCH: pc_next = branch_target;
         PC_SRC_JUMP:   pc_next = jump_target;
         PC_SRC_HOLD:   pc_next = pc;
         default:       pc_next = pc;
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem read per if_enable
// and defers PC updates that land while a read is outstanding.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT),
   parameter int                    PC_INC     = 1,
   parameter int                    TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_enable,
   input  logic                  pc_write,
   input  logic [1:0]            pc_src,
   input  logic [ADDR_WIDTH-1:0] branch_target,
   input  logic [ADDR_WIDTH-1:0] jump_target,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_ack,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic [ADDR_WIDTH-1:0] pc_next_seq,
   output logic [DATA_WIDTH-1:0] instr,
   output logic                  instr_valid,
   output logic                  fetch_busy,
   output logic                  fetch_err
);

   localparam int                    TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [TW-1:0]         TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [ADDR_WIDTH-1:0] INC      = ADDR_WIDTH'(PC_INC);

   fetch_state_e          state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] link_q, link_d;
   logic [DATA_WIDTH-1:0] instr_q, instr_d;
   logic                  valid_q, valid_d;
   logic                  err_q, err_d;
   logic [ADDR_WIDTH-1:0] pend_q, pend_d;
   logic                  pend_vld_q, pend_vld_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic [ADDR_WIDTH-1:0] pc_new;
   logic                  req_end;

   pc_next_mux #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .PC_INC     (PC_INC)
   ) u_pc_next_mux (
      .pc            (pc_q),
      .pc_src        (pc_src),
      .branch_target (branch_target),
      .jump_target   (jump_target),
      .pc_next       (pc_new)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      addr_d     = addr_q;
      link_d     = link_q;
      instr_d    = instr_q;
      valid_d    = valid_q;
      err_d      = err_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      tmo_d      = tmo_q;
      req_end    = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (if_enable) begin
               state_d = ST_REQ;
               addr_d  = pc_q;
               valid_d = 1'b0;
               tmo_d   = '0;
            end
         end
         ST_REQ: begin
            // A new fetch while one is outstanding is an overrun: flag and drop it.
            if (if_enable) err_d = 1'b1;
            if (imem_ack) begin
               instr_d = imem_rdata;
               link_d  = addr_q + INC;
               valid_d = 1'b1;
               state_d = ST_DONE;
               req_end = 1'b1;
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
               req_end = 1'b1;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // PC is frozen during REQ; the latest write is released when REQ ends.
      if (state_q != ST_REQ) begin
         if (pc_write) pc_d = pc_new;
      end else begin
         if (pc_write) begin
            pend_d     = pc_new;
            pend_vld_d = 1'b1;
         end
         if (req_end) begin
            pend_vld_d = 1'b0;
            if (pc_write)        pc_d = pc_new;
            else if (pend_vld_q) pc_d = pend_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC;
         addr_q     <= '0;
         link_q     <= '0;
         instr_q    <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         tmo_q      <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         addr_q     <= addr_d;
         link_q     <= link_d;
         instr_q    <= instr_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         tmo_q      <= tmo_d;
      end
   end

   assign imem_req    = (state_q == ST_REQ);
   assign fetch_busy  = (state_q == ST_REQ);
   assign imem_addr   = addr_q;
   assign pc          = pc_q;
   assign pc_next_seq = link_q;
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// fetch/PC-update run checked against a transaction-level PC model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_enable, pc_write;
   logic [1:0]  pc_src;
   logic [31:0] branch_target, jump_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] pc, pc_next_seq, instr;
   logic        instr_valid, fetch_busy, fetch_err;

   int checks   = 0;
   int failures = 0;

   fetch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .if_enable     (if_enable),
      .pc_write      (pc_write),
      .pc_src        (pc_src),
      .branch_target (branch_target),
      .jump_target   (jump_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .pc            (pc),
      .pc_next_seq   (pc_next_seq),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .fetch_busy    (fetch_busy),
      .fetch_err     (fetch_err)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
      $fatal(1, "watchdog");
   end

   // Next-PC rule: 00 seq (+1 mod 2^32), 01 branch, 10 jump, 11 hold.
   function automatic logic [31:0] model_next(input logic [31:0] p, input logic [1:0] s,
                                              input logic [31:0] bt, input logic [31:0] jt);
      case (s)
         2'b00:   return p + 32'd1;
         2'b01:   return bt;
         2'b10:   return jt;
         default: return p;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      if_enable = 0; pc_write = 0; pc_src = 0;
      branch_target = 0; jump_target = 0;
      imem_ack = 0; imem_rdata = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 0;
      step(); step();
      rst = 1;
      step();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 0;
      #2;
      checks++;
      if (pc !== 32'h0 || instr !== 32'h0 || pc_next_seq !== 32'h0 || imem_addr !== 32'h0) begin
         failures++;
         $display("FAIL reset_regs: pc=%h instr=%h link=%h addr=%h required all 0", pc, instr, pc_next_seq, imem_addr);
      end
      checks++;
      if ({imem_req, instr_valid, fetch_busy, fetch_err} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags: req/valid/busy/err=%b required 0000", {imem_req, instr_valid, fetch_busy, fetch_err});
      end
      step(); rst = 1; step();
   endtask

   task automatic test_first_fetch();
      do_reset();
      if_enable = 1; step(); if_enable = 0;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || fetch_busy !== 1'b1) begin
         failures++;
         $display("FAIL first_req: req=%b addr=%h busy=%b required 1 00000000 1", imem_req, imem_addr, fetch_busy);
      end
      imem_ack = 1; imem_rdata = 32'hDEADBEEF; step(); imem_ack = 0;
      checks++;
      if (instr !== 32'hDEADBEEF || instr_valid !== 1'b1 || pc_next_seq !== 32'h1 || imem_req !== 1'b0) begin
         failures++;
         $display("FAIL first_data: instr=%h valid=%b link=%h req=%b required deadbeef 1 1 0", instr, instr_valid, pc_next_seq, imem_req);
      end
   endtask

   task automatic test_cadence();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         if_enable = 1; step(); if_enable = 0;
         checks++;
         if (imem_addr !== 32'(k) || imem_req !== 1'b1) begin
            failures++;
            $display("FAIL cadence_addr[%0d]: addr=%h req=%b required %h 1", k, imem_addr, imem_req, 32'(k));
         end
         imem_ack = 1; imem_rdata = $urandom; step(); imem_ack = 0;
         step(); step();
         pc_write = 1; pc_src = 2'b00; step(); pc_write = 0;
         checks++;
         if (pc !== 32'(k + 1)) begin
            failures++;
            $display("FAIL cadence_pc[%0d]: pc=%h required %h", k, pc, 32'(k + 1));
         end
      end
   endtask

   task automatic test_deferred_branch();
      do_reset();
      if_enable = 1; step(); if_enable = 0;
      pc_write = 1; pc_src = 2'b01; branch_target = 32'h40; step(); pc_write = 0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (imem_addr !== 32'h0 || pc !== 32'h0 || imem_req !== 1'b1) begin
            failures++;
            $display("FAIL defer_hold[%0d]: addr=%h pc=%h req=%b required 0 0 1", i, imem_addr, pc, imem_req);
         end
         step();
      end
      checks++;
      if (imem_addr !== 32'h0 || pc !== 32'h0) begin
         failures++;
         $display("FAIL defer_hold[2]: addr=%h pc=%h required 0 0", imem_addr, pc);
      end
      imem_ack = 1; imem_rdata = 32'h1234_5678; step(); imem_ack = 0;
      checks++;
      if (pc !== 32'h40 || instr_valid !== 1'b1 || pc_next_seq !== 32'h1) begin
         failures++;
         $display("FAIL defer_commit: pc=%h valid=%b link=%h required 40 1 1", pc, instr_valid, pc_next_seq);
      end
   endtask

   task automatic test_timeout();
      int n;
      do_reset();
      if_enable = 1; step(); if_enable = 0;
      n = 0;
      while (imem_req === 1'b1 && n < 40) begin
         step(); n++;
      end
      checks++;
      if (n != 15) begin
         failures++;
         $display("FAIL timeout_len: req cycles=%0d required 15", n);
      end
      checks++;
      if (fetch_err !== 1'b1 || instr_valid !== 1'b0 || fetch_busy !== 1'b0) begin
         failures++;
         $display("FAIL timeout_flags: err=%b valid=%b busy=%b required 1 0 0", fetch_err, instr_valid, fetch_busy);
      end
      step(); step();
      checks++;
      if (fetch_err !== 1'b1) begin
         failures++;
         $display("FAIL err_sticky: err=%b required 1", fetch_err);
      end
   endtask

   task automatic test_overrun();
      do_reset();
      if_enable = 1; step();
      step(); if_enable = 0;
      checks++;
      if (fetch_err !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         failures++;
         $display("FAIL overrun: err=%b req=%b addr=%h required 1 1 0", fetch_err, imem_req, imem_addr);
      end
      imem_ack = 1; imem_rdata = 32'hA5A5_0001; step(); imem_ack = 0;
      checks++;
      if (instr !== 32'hA5A5_0001 || instr_valid !== 1'b1) begin
         failures++;
         $display("FAIL overrun_done: instr=%h valid=%b required a5a50001 1", instr, instr_valid);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      pc_write = 1; pc_src = 2'b10; jump_target = 32'hFFFF_FFFF; step();
      pc_src = 2'b00; step();
      checks++;
      if (pc !== 32'h0) begin
         failures++;
         $display("FAIL wrap_seq: pc=%h required 00000000", pc);
      end
      pc_src = 2'b10; step();
      pc_src = 2'b11; step(); pc_write = 0;
      checks++;
      if (pc !== 32'hFFFF_FFFF) begin
         failures++;
         $display("FAIL hold: pc=%h required ffffffff", pc);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      pc_write = 1; pc_src = 2'b10; jump_target = 32'h1234; step(); pc_write = 0;
      if_enable = 1; step(); if_enable = 0;
      #2 rst = 0;
      #1;
      checks++;
      if (imem_req !== 1'b0 || pc !== 32'h0 || fetch_busy !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: req=%b pc=%h busy=%b required 0 0 0", imem_req, pc, fetch_busy);
      end
      @(posedge clk); #1 rst = 1;
      imem_ack = 1; imem_rdata = 32'hCAFE_F00D; step(); imem_ack = 0;
      checks++;
      if (instr_valid !== 1'b0 || instr !== 32'h0 || imem_req !== 1'b0) begin
         failures++;
         $display("FAIL stale_ack: valid=%b instr=%h req=%b required 0 0 0", instr_valid, instr, imem_req);
      end
   endtask

   task automatic test_random();
      logic [31:0] exp_pc, faddr, pend, data, bt, jt;
      logic [1:0]  src;
      bit          has_pend;
      int          d, errs;
      do_reset();
      exp_pc = 32'h0;
      errs = 0;
      for (int it = 0; it < 40; it++) begin
         if_enable = 1;
         faddr = exp_pc;
         if ($urandom_range(0, 3) == 0) begin
            src = 2'($urandom); bt = $urandom; jt = $urandom;
            pc_write = 1; pc_src = src; branch_target = bt; jump_target = jt;
            exp_pc = model_next(exp_pc, src, bt, jt);
         end
         step(); if_enable = 0; pc_write = 0;
         if (imem_addr !== faddr || imem_req !== 1'b1) begin
            errs++;
            $display("FAIL rnd_req[%0d]: addr=%h req=%b required %h 1", it, imem_addr, imem_req, faddr);
         end
         d = $urandom_range(0, 6);
         has_pend = 0;
         data = $urandom;
         for (int i = 0; i <= d; i++) begin
            imem_ack = (i == d);
            imem_rdata = (i == d) ? data : $urandom;
            if ($urandom_range(0, 3) == 0) begin
               src = 2'($urandom); bt = $urandom; jt = $urandom;
               pc_write = 1; pc_src = src; branch_target = bt; jump_target = jt;
               pend = model_next(exp_pc, src, bt, jt);
               has_pend = 1;
            end
            step(); imem_ack = 0; pc_write = 0;
            if (i < d && (pc !== exp_pc || imem_addr !== faddr)) begin
               errs++;
               $display("FAIL rnd_wait[%0d]: pc=%h addr=%h required %h %h", it, pc, imem_addr, exp_pc, faddr);
            end
         end
         if (has_pend) exp_pc = pend;
         if (pc !== exp_pc || instr !== data || instr_valid !== 1'b1 ||
             pc_next_seq !== faddr + 32'd1 || imem_req !== 1'b0) begin
            errs++;
            $display("FAIL rnd_done[%0d]: pc=%h instr=%h valid=%b link=%h req=%b required %h %h 1 %h 0",
                     it, pc, instr, instr_valid, pc_next_seq, imem_req, exp_pc, data, faddr + 32'd1);
         end
         if ($urandom_range(0, 1) == 1) begin
            src = 2'($urandom); bt = $urandom; jt = $urandom;
            pc_write = 1; pc_src = src; branch_target = bt; jump_target = jt;
            exp_pc = model_next(exp_pc, src, bt, jt);
         end
         step(); pc_write = 0;
         if (pc !== exp_pc) begin
            errs++;
            $display("FAIL rnd_idle_pc[%0d]: pc=%h required %h", it, pc, exp_pc);
         end
      end
      checks++;
      if (errs != 0) begin
         failures++;
         $display("FAIL rnd_summary: %0d mismatching random steps, required 0", errs);
      end
      checks++;
      if (fetch_err !== 1'b0) begin
         failures++;
         $display("FAIL rnd_err: err=%b required 0", fetch_err);
      end
   endtask

   initial begin
      clear_inputs();
      rst = 0;
      test_reset();
      test_first_fetch();
      test_cadence();
      test_deferred_branch();
      test_timeout();
      test_overrun();
      test_wrap();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the multi-cycle core, directly downstream of the clock-phase counter. It owns the PC register and launches one instruction-memory read per if_enable pulse. It latches the returned word into the instruction register and applies the PC update on each pc_write pulse. It keeps the memory address stable while a read is outstanding and defers any PC update that arrives mid-fetch.

Parameters:
ADDR_WIDTH, 32, width of PC and instruction-memory address
DATA_WIDTH, 32, instruction word width
RESET_PC, 0, PC value loaded on reset
PC_INC, 1, sequential increment (word-addressed memory)
TIMEOUT, 15, max cycles waiting for imem_ack before flagging an error (≥1)

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
if_enable  in  1  one-cycle pulse from phase counter: start a fetch
pc_write  in  1  one-cycle pulse from phase counter: commit next PC
pc_src  in  2  next-PC select: 00 pc+PC_INC, 01 branch_target, 10 jump_target, 11 hold
branch_target  in  ADDR_WIDTH  branch destination
jump_target  in  ADDR_WIDTH  jump destination
imem_req  out  1  read request, held until acknowledged
imem_addr  out  ADDR_WIDTH  read address (= pc captured at request start)
imem_ack  in  1  memory accepts and returns data this cycle
imem_rdata  in  DATA_WIDTH  instruction word, valid with imem_ack
pc  out  ADDR_WIDTH  current PC
pc_next_seq  out  ADDR_WIDTH  registered pc+PC_INC of the fetched instruction (link value)
instr  out  DATA_WIDTH  instruction register
instr_valid  out  1  instr holds a completed fetch for the current cycle group
fetch_busy  out  1  read outstanding (state REQ)
fetch_err  out  1  sticky: timeout or overrun occurred

Behaviour:
- Reset (rst=0, async): pc=RESET_PC; instr=0; pc_next_seq=0; instr_valid=0; imem_req=0; imem_addr=0; fetch_err=0; pending write cleared; timeout counter=0; FSM=IDLE.
- FSM states: IDLE, REQ, DONE.
  - IDLE: on if_enable, next cycle enters REQ with imem_req=1 and imem_addr=pc (captured); instr_valid cleared.
  - REQ: imem_req stays 1 and imem_addr is held.
    - On imem_ack: instr<=imem_rdata, pc_next_seq<=imem_addr+PC_INC, instr_valid<=1, imem_req<=0, go to DONE.
    - Timeout counter increments each REQ cycle without ack. On reaching TIMEOUT: fetch_err<=1, imem_req<=0, go to IDLE, instr_valid stays 0.
  - DONE: instr held; on if_enable, behave as IDLE (new request next cycle).
- Minimum fetch latency: if_enable at cycle N, request at N+1, with ack at N+1 instr_valid=1 at N+2.
- PC update on pc_write:
  - Next PC is computed from pc_src, branch_target and jump_target sampled in the pc_write cycle.
  - Arithmetic is modulo 2^ADDR_WIDTH, so 0xFFFFFFFF+1 = 0.
  - Outside REQ, pc updates at the next edge.
  - In REQ, the computed value is stored as pending and committed on the edge where imem_ack (or timeout) ends REQ. imem_addr never changes mid-request.
  - A second pc_write while pending overwrites the pending value.
- Overrun: if_enable arriving in REQ sets fetch_err=1 and is ignored; the current fetch continues.
- if_enable and pc_write in the same cycle: the fetch uses the old pc, and the PC update applies normally.
- fetch_err clears only on reset.

Decomposition:
- Shared package: pc_src encodings (PC_SRC_SEQ/BRANCH/JUMP/HOLD), FSM state encodings, RESET_PC default.
- One natural sub-module: pc_next_mux (combinational next-PC select and increment), reusable by the branch unit.

Test Plan:
- Reset then release; if_enable at cycle 1, imem_ack immediate with rdata 0xDEADBEEF -> imem_addr=0 at cycle 2, instr=0xDEADBEEF and instr_valid=1 at cycle 3, pc_next_seq=1.
- Counter cadence (if_enable every 5 cycles, pc_write 4 cycles later), pc_src=00, 3 periods -> pc goes 0→1→2→3, imem_addr 0,1,2.
- pc_write with pc_src=01, branch_target=0x40, during REQ with ack delayed 3 cycles -> imem_addr stays 0 throughout, pc=0x40 one edge after ack.
- imem_ack never asserted, TIMEOUT=15 -> imem_req drops after 15 REQ cycles, fetch_err=1, instr_valid=0.
- pc=0xFFFFFFFF, pc_write with pc_src=00 -> pc=0x00000000; pc_src=11 -> pc unchanged.
- rst driven low mid-REQ, asynchronous to clk -> imem_req=0, pc=RESET_PC immediately; a stale ack after release is ignored.
